// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
//
// Multi-cycle instruction fetch / decode sequencer. An instruction is read from
// a word-addressed instruction memory with a req/ack handshake. It is latched
// into IR and split into register-file addresses, an immediate and ALU
// controls. One cycle is left for the downstream ALU to settle. Then the
// register file is written for one cycle and the PC advances.
// The all-ones word is HALT. HALT stops the sequencer until rst_n is asserted.
//
// Optional feature (compile-time macro):
//   RETIRE_CNT_EN  - when defined, retire_cnt counts WB cycles and saturates
//                    at 16'hFFFF. When undefined, retire_cnt is tied to 0 and
//                    no counter flop exists.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   begin execution at the current PC (sampled in IDLE only)
//   imem_req    out  instruction read request (high throughout FETCH)
//   imem_addr   out  instruction address, always equal to PC
//   imem_ack    in   imem_rdata valid this cycle (ignored outside FETCH)
//   imem_rdata  in   instruction word
//   rs, rt, rd  out  register-file read/write addresses
//   imm_in      out  raw immediate, sign-extended downstream
//   mux_sel     out  1 = immediate operand B, 0 = register operand B
//   ALUopsel    out  [3] mode, [2:0] opsel
//   we          out  register-file write enable (WB cycle only)
//   busy        out  high in FETCH, DECODE, EXEC and WB
//   halted      out  high in HALT
//   retire_cnt  out  retired-instruction count (see RETIRE_CNT_EN)
// -----------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 6,
  parameter int IMM_IN = 15,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic [RWIDTH-1:0] rs,
  output logic [RWIDTH-1:0] rt,
  output logic [RWIDTH-1:0] rd,
  output logic [IMM_IN-1:0] imm_in,
  output logic              mux_sel,
  output logic [3:0]        ALUopsel,
  output logic              we,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // Instruction layout, anchored at the MSB:
  //   [31:28] ALUopsel  [27] mux_sel  [26:21] rd  [20:15] rs  [14:9] rt
  //   [14:0]  imm_in    (rt and imm_in overlap; the opcode decides which is used)
  localparam int OP_MSB  = DWIDTH - 1;
  localparam int MUX_BIT = DWIDTH - 5;
  localparam int RD_MSB  = DWIDTH - 6;
  localparam int RS_MSB  = RD_MSB - RWIDTH;
  localparam int RT_MSB  = RS_MSB - RWIDTH;

  localparam logic [DWIDTH-1:0] HALT_WORD = '1;

  state_t              state;
  logic [AWIDTH-1:0]   pc;
  logic [DWIDTH-1:0]   ir;

  assign imem_addr = pc;

  // Single-process FSM. Every control output is a flop. Each output is
  // assigned together with the state it belongs to, so the value matches
  // the state without combinational decode. The async reset therefore clears
  // the outputs immediately. It aborts any FETCH or WB in flight. The PC
  // increment and the retire count both happen on the edge that leaves WB,
  // so a reset during WB makes neither change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: IR and the decoded fields are ordinary flops, not a memory
      // array. Resetting them is cheap and gives a defined all-zero interface
      // straight out of reset.
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      imem_req <= 1'b0;
      we       <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      imm_in   <= '0;
      mux_sel  <= 1'b0;
      ALUopsel <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // right-hand side then reads the pre-edge value, whatever the statement
      // order.
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end

        // While waiting for ack, the request and the address (the PC) stay
        // unchanged. An ack in the first FETCH cycle completes the fetch
        // with no wait state.
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end

        // HALT leaves the field outputs untouched. They keep the last real
        // instruction's values.
        S_DECODE: begin
          if (ir == HALT_WORD) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            ALUopsel <= ir[OP_MSB -: 4];
            mux_sel  <= ir[MUX_BIT];
            rd       <= ir[RD_MSB -: RWIDTH];
            rs       <= ir[RS_MSB -: RWIDTH];
            rt       <= ir[RT_MSB -: RWIDTH];
            imm_in   <= ir[IMM_IN-1:0];
            state    <= S_EXEC;
          end
        end

        // ALU settling cycle. we is raised here so that it is high during
        // exactly the WB cycle.
        S_EXEC: begin
          we    <= 1'b1;
          state <= S_WB;
        end

        // The PC wraps naturally at 2^AWIDTH. imem_req rises only as we
        // falls, so the two are never high together.
        S_WB: begin
          we       <= 1'b0;
          pc       <= pc + 1'b1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          we       <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RETIRE_CNT_EN
  // One count per WB cycle, saturating so a long run never wraps to a small
  // number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (state == S_WB && retire_cnt != 16'hFFFF) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_decode
//
// Self-checking bench for instr_fetch_decode. A memory responder with a
// per-address ack delay feeds a main instance (AWIDTH=8). The responder can
// also inject noise: ack pulses outside FETCH and start pulses while the DUT
// is busy or halted. A second instance (AWIDTH=2) covers PC wrap-around.
// Expected values come from the instruction word by shift/mask arithmetic,
// and from the rule that each instruction takes 4 cycles plus its wait
// cycles.
// -----------------------------------------------------------------------------
module tb_instr_fetch_decode;

  localparam int DW   = 32;
  localparam int RW   = 6;
  localparam int IW   = 15;
  localparam int AW   = 8;
  localparam int AW_W = 2;

`ifdef RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst_n, start, imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [RW-1:0] rs, rt, rd;
  logic [IW-1:0] imm_in;
  logic          mux_sel;
  logic [3:0]    ALUopsel;
  logic          we, busy, halted;
  logic [15:0]   retire_cnt;

  // wrap-around instance
  logic            w_rst_n, w_start, w_ack;
  logic [DW-1:0]   w_rdata;
  logic            w_imem_req;
  logic [AW_W-1:0] w_imem_addr;
  logic [RW-1:0]   w_rs, w_rt, w_rd;
  logic [IW-1:0]   w_imm_in;
  logic            w_mux_sel;
  logic [3:0]      w_ALUopsel;
  logic            w_we, w_busy, w_halted;
  logic [15:0]     w_retire_cnt;

  instr_fetch_decode #(.DWIDTH(DW), .RWIDTH(RW), .IMM_IN(IW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs(rs), .rt(rt), .rd(rd), .imm_in(imm_in), .mux_sel(mux_sel), .ALUopsel(ALUopsel),
    .we(we), .busy(busy), .halted(halted), .retire_cnt(retire_cnt)
  );

  instr_fetch_decode #(.DWIDTH(DW), .RWIDTH(RW), .IMM_IN(IW), .AWIDTH(AW_W)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .start(w_start),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm_in(w_imm_in), .mux_sel(w_mux_sel), .ALUopsel(w_ALUopsel),
    .we(w_we), .busy(w_busy), .halted(w_halted), .retire_cnt(w_retire_cnt)
  );

  int errors = 0;
  int checks = 0;

  // program image and per-address ack delay for the main instance
  logic [31:0] mem [256];
  int          delay_tab [256];
  bit          noise_en;

  // observations collected by run_prog
  logic [37:0] obs_fields [64];
  int          obs_lat [64];
  int          obs_addr [64];
  int          obs_n, obs_caps, obs_addr_chg, obs_overlap;
  bit          obs_timeout;

  // Reference decode: fields straight from the bit layout, by shift and mask.
  function automatic logic [37:0] model_fields(input logic [31:0] w);
    int unsigned u;
    u = w;
    return {4'((u >> 28) & 32'hF), 1'((u >> 27) & 32'h1), 6'((u >> 21) & 32'h3F),
            6'((u >> 15) & 32'h3F), 6'((u >> 9) & 32'h3F), 15'(u & 32'h7FFF)};
  endfunction

  function automatic logic [37:0] dut_fields();
    return {ALUopsel, mux_sel, rd, rs, rt, imm_in};
  endfunction

  function automatic logic [31:0] rand_alu();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
    return w;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 32'h0;
      delay_tab[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulses start, then acts as the instruction memory and records what the
  // DUT does. Returns when the DUT halts, or when stop_wb WB cycles have been
  // seen (stop_wb > 0), or after budget cycles (obs_timeout set).
  task automatic run_prog(input int stop_wb, input int budget);
    int  cyc, wait_cnt, fetch_start, cur_addr;
    bit  in_fetch, done;
    for (int i = 0; i < 64; i++) begin
      obs_fields[i] = 'x; obs_lat[i] = -1; obs_addr[i] = -1;
    end
    obs_n = 0; obs_caps = 0; obs_addr_chg = 0; obs_overlap = 0; obs_timeout = 1'b0;
    wait_cnt = 0; fetch_start = 0; cur_addr = 0; in_fetch = 1'b0; done = 1'b0;
    @(negedge clk);
    start = 1'b1; imem_ack = 1'b0;
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (we && imem_req) obs_overlap++;
      if (imem_req && !in_fetch) begin
        in_fetch = 1'b1; fetch_start = cyc; cur_addr = int'(imem_addr);
        if (obs_n < 64) obs_addr[obs_n] = int'(imem_addr);
      end else if (imem_req && int'(imem_addr) != cur_addr) begin
        obs_addr_chg++;
      end
      if (!imem_req) in_fetch = 1'b0;
      if (we) begin
        if (obs_n < 64) begin
          obs_fields[obs_n] = dut_fields();
          obs_lat[obs_n]    = cyc - fetch_start;
        end
        obs_n++;
      end
      if (halted || (stop_wb > 0 && obs_n == stop_wb)) begin
        done = 1'b1;
      end else if (imem_req) begin
        if (wait_cnt >= delay_tab[imem_addr]) begin
          imem_ack = 1'b1; imem_rdata = mem[imem_addr]; obs_caps++; wait_cnt = 0;
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom; wait_cnt++;
        end
      end else begin
        imem_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = $urandom;
        wait_cnt = 0;
      end
    end
    obs_timeout = !done;
    start = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %0h expected 0", imem_req); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h expected 0", we); end
    checks++; if ({busy, halted} !== 2'b00) begin errors++; $display("FAIL reset_busy_halted: got %0b expected 00", {busy, halted}); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", imem_addr); end
    checks++; if (dut_fields() !== 38'h0) begin errors++; $display("FAIL reset_fields: got %0h expected 0", dut_fields()); end
    checks++; if (retire_cnt !== 16'h0) begin errors++; $display("FAIL reset_retire: got %0h expected 0", retire_cnt); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    w = 32'h2860_8005;  // ALUopsel=2, mux_sel=1, rd=3, rs=1, imm=5
    do_reset(); clear_prog(); noise_en = 1'b0;
    mem[0] = w; mem[1] = 32'hFFFF_FFFF;
    run_prog(0, 100);
    checks++; if (obs_timeout) begin errors++; $display("FAIL zw_timeout: got timeout expected halt"); end
    checks++; if (obs_n != 1) begin errors++; $display("FAIL zw_we_count: got %0d expected 1", obs_n); end
    checks++; if (obs_lat[0] != 3) begin errors++; $display("FAIL zw_we_cycle: got %0d expected 3", obs_lat[0]); end
    checks++; if (obs_fields[0] !== model_fields(w)) begin errors++; $display("FAIL zw_fields: got %0h expected %0h", obs_fields[0], model_fields(w)); end
    checks++; if (obs_fields[0] !== {4'h2, 1'b1, 6'd3, 6'd1, 6'd0, 15'h0005}) begin errors++; $display("FAIL zw_fields_lit: got %0h", obs_fields[0]); end
    checks++; if (imem_addr !== 8'd1) begin errors++; $display("FAIL zw_pc: got %0h expected 1", imem_addr); end
  endtask

  task automatic test_wait_states();
    do_reset(); clear_prog(); noise_en = 1'b1;
    mem[0] = rand_alu(); mem[1] = 32'hFFFF_FFFF; delay_tab[0] = 3;
    run_prog(0, 100);
    checks++; if (obs_timeout) begin errors++; $display("FAIL ws_timeout: got timeout expected halt"); end
    checks++; if (obs_n != 1) begin errors++; $display("FAIL ws_we_count: got %0d expected 1", obs_n); end
    checks++; if (obs_caps != 2) begin errors++; $display("FAIL ws_captures: got %0d expected 2", obs_caps); end
    checks++; if (obs_addr_chg != 0) begin errors++; $display("FAIL ws_addr_stable: got %0d changes expected 0", obs_addr_chg); end
    checks++; if (obs_lat[0] != 6) begin errors++; $display("FAIL ws_we_cycle: got %0d expected 6", obs_lat[0]); end
    checks++; if (obs_fields[0] !== model_fields(mem[0])) begin errors++; $display("FAIL ws_fields: got %0h expected %0h", obs_fields[0], model_fields(mem[0])); end
  endtask

  task automatic test_halt();
    int bad;
    do_reset(); clear_prog(); noise_en = 1'b1;
    mem[0] = rand_alu(); mem[1] = rand_alu(); mem[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) delay_tab[i] = $urandom_range(0, 2);
    run_prog(0, 100);
    checks++; if (obs_n != 2) begin errors++; $display("FAIL halt_we_count: got %0d expected 2", obs_n); end
    checks++; if ({halted, busy, imem_req} !== 3'b100) begin errors++; $display("FAIL halt_flags: got %0b expected 100", {halted, busy, imem_req}); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (we || imem_req || !halted || busy) bad++;
      start = 1'($urandom_range(0, 1)); imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
    end
    start = 1'b0; imem_ack = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_terminal: got %0d bad cycles expected 0", bad); end
    checks++; if (dut_fields() !== model_fields(mem[1])) begin errors++; $display("FAIL halt_fields_hold: got %0h expected %0h", dut_fields(), model_fields(mem[1])); end
    checks++; if (imem_addr !== 8'd2) begin errors++; $display("FAIL halt_pc: got %0h expected 2", imem_addr); end
  endtask

  task automatic test_random_program();
    int n;
    do_reset(); clear_prog(); noise_en = 1'b1;
    n = $urandom_range(8, 14);
    for (int i = 0; i < n; i++) begin
      mem[i] = rand_alu(); delay_tab[i] = $urandom_range(0, 3);
    end
    mem[n] = 32'hFFFF_FFFF;
    run_prog(0, 400);
    checks++; if (obs_timeout) begin errors++; $display("FAIL rnd_timeout: got timeout expected halt"); end
    checks++; if (obs_n != n) begin errors++; $display("FAIL rnd_we_count: got %0d expected %0d", obs_n, n); end
    for (int k = 0; k < n; k++) begin
      checks++; if (obs_fields[k] !== model_fields(mem[k])) begin errors++; $display("FAIL rnd_fields[%0d]: got %0h expected %0h", k, obs_fields[k], model_fields(mem[k])); end
      checks++; if (obs_lat[k] != 3 + delay_tab[k]) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", k, obs_lat[k], 3 + delay_tab[k]); end
      checks++; if (obs_addr[k] != k) begin errors++; $display("FAIL rnd_addr[%0d]: got %0d expected %0d", k, obs_addr[k], k); end
    end
    checks++; if (obs_overlap != 0) begin errors++; $display("FAIL rnd_we_req_overlap: got %0d expected 0", obs_overlap); end
    checks++; if (obs_caps != n + 1) begin errors++; $display("FAIL rnd_captures: got %0d expected %0d", obs_caps, n + 1); end
    checks++; if (retire_cnt !== (CNT_EN ? 16'(n) : 16'h0)) begin errors++; $display("FAIL rnd_retire: got %0d expected %0d", retire_cnt, CNT_EN ? n : 0); end
  endtask

  task automatic test_retire_count();
    do_reset(); clear_prog(); noise_en = 1'b0;
    for (int i = 0; i < 5; i++) mem[i] = rand_alu();
    mem[5] = 32'hFFFF_FFFF;
    run_prog(0, 200);
    checks++; if (obs_n != 5) begin errors++; $display("FAIL rc_we_count: got %0d expected 5", obs_n); end
    checks++; if (retire_cnt !== (CNT_EN ? 16'd5 : 16'd0)) begin errors++; $display("FAIL rc_value: got %0d expected %0d", retire_cnt, CNT_EN ? 5 : 0); end
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_prog(); noise_en = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = {4'h5, 28'($urandom)};
    delay_tab[1] = 6;
    // abort during a wait-stated FETCH of the second instruction
    run_prog(1, 100);
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 8'd1}) begin errors++; $display("FAIL mid_fetch_pre: got %0h expected 101", {imem_req, imem_addr}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({imem_req, we, busy, halted} !== 4'b0) begin errors++; $display("FAIL mid_fetch_ctrl: got %0b expected 0000", {imem_req, we, busy, halted}); end
    checks++; if (dut_fields() !== 38'h0) begin errors++; $display("FAIL mid_fetch_fields: got %0h expected 0", dut_fields()); end
    checks++; if ({imem_addr, retire_cnt} !== 24'h0) begin errors++; $display("FAIL mid_fetch_pc_cnt: got %0h expected 0", {imem_addr, retire_cnt}); end
    @(negedge clk); rst_n = 1'b1;
    // abort during WB: no write completes, no PC advance, no count
    run_prog(1, 100);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL mid_wb_pre: got %0h expected 1", we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({we, imem_addr, retire_cnt} !== 25'h0) begin errors++; $display("FAIL mid_wb_abort: got %0h expected 0", {we, imem_addr, retire_cnt}); end
    @(negedge clk); rst_n = 1'b1;
    run_prog(1, 100);
    checks++; if (obs_addr[0] != 0) begin errors++; $display("FAIL mid_restart_addr: got %0d expected 0", obs_addr[0]); end
    checks++; if (obs_fields[0] !== model_fields(mem[0])) begin errors++; $display("FAIL mid_restart_fields: got %0h expected %0h", obs_fields[0], model_fields(mem[0])); end
  endtask

  task automatic test_start_at_release();
    @(negedge clk); rst_n = 1'b0; start = 1'b1; imem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if ({imem_req, busy} !== 2'b11) begin errors++; $display("FAIL start_at_release: got %0b expected 11", {imem_req, busy}); end
    do_reset();
  endtask

  task automatic test_wrap();
    int fa [8];
    int nf, wb;
    bit prev_req;
    for (int i = 0; i < 8; i++) fa[i] = -1;
    @(negedge clk); w_rst_n = 1'b0; w_start = 1'b0; w_ack = 1'b1; w_rdata = 32'h1234_5678;
    @(negedge clk); w_rst_n = 1'b1;
    @(negedge clk); w_start = 1'b1;
    nf = 0; wb = 0; prev_req = 1'b0;
    for (int c = 0; c < 40 && wb < 4; c++) begin
      @(negedge clk);
      w_start = 1'b0;
      if (w_imem_req && !prev_req && nf < 8) begin fa[nf] = int'(w_imem_addr); nf++; end
      prev_req = w_imem_req;
      if (w_we) wb++;
    end
    checks++; if (wb != 4) begin errors++; $display("FAIL wrap_wb_count: got %0d expected 4", wb); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (fa[k] != k % (1 << AW_W)) begin errors++; $display("FAIL wrap_fetch_addr[%0d]: got %0d expected %0d", k, fa[k], k % (1 << AW_W)); end
    end
    @(negedge clk);
    checks++; if ({w_imem_req, w_imem_addr} !== {1'b1, 2'd0}) begin errors++; $display("FAIL wrap_addr_after: got %0h expected 4", {w_imem_req, w_imem_addr}); end
    w_rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    w_rst_n = 1'b0; w_start = 1'b0; w_ack = 1'b0; w_rdata = '0;
    noise_en = 1'b0;
    clear_prog();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_halt();
    test_random_program();
    test_retire_count();
    test_reset_mid();
    test_start_at_release();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
